// File: rtl/seq_stim_pkg.sv
// rtl/seq_stim_pkg.sv - shared types and constants for the trigger/response stimulus generator
package seq_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_GAP  = 3'd4
    } seq_state_e;

    localparam int A_IDLE_DEF = 1;
    localparam int B_IDLE_DEF = 4;
    localparam logic [3:0] DELAY_MIN = 4'd1;

endpackage

// File: rtl/seq_stim_gen.sv
// rtl/seq_stim_gen.sv - drives a trigger on a, then a (optionally corrupted) response on b after a programmable delay
module seq_stim_gen
    import seq_stim_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int A_IDLE = A_IDLE_DEF,
    parameter int B_IDLE = B_IDLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        delay_cfg,
    input  logic [7:0]        reps,
    input  logic              inject_err,
    input  logic [DATA_W-1:0] trig_val,
    input  logic [DATA_W-1:0] resp_val,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [7:0]        seq_cnt
);

    localparam logic [DATA_W-1:0] A_IDLE_V = DATA_W'(A_IDLE);
    localparam logic [DATA_W-1:0] B_IDLE_V = DATA_W'(B_IDLE);

    seq_state_e        state, state_n;
    logic [3:0]        dly_cnt, dly_n, dly_lat;
    logic [7:0]        rep_cnt, rep_n, cnt_n;
    logic [DATA_W-1:0] trig_lat, resp_lat, resp_eff, a_n, b_n;
    logic              inject_lat, latch, done_n, busy_n;

    assign resp_eff = resp_lat + {{(DATA_W-1){1'b0}}, inject_lat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dly_cnt    <= '0;
            rep_cnt    <= '0;
            dly_lat    <= '0;
            trig_lat   <= '0;
            resp_lat   <= '0;
            inject_lat <= 1'b0;
            a          <= A_IDLE_V;
            b          <= B_IDLE_V;
            busy       <= 1'b0;
            done       <= 1'b0;
            seq_cnt    <= '0;
        end else begin
            state   <= state_n;
            dly_cnt <= dly_n;
            rep_cnt <= rep_n;
            a       <= a_n;
            b       <= b_n;
            busy    <= busy_n;
            done    <= done_n;
            seq_cnt <= cnt_n;
            if (latch) begin
                dly_lat    <= (delay_cfg == 4'd0) ? DELAY_MIN : delay_cfg;
                trig_lat   <= trig_val;
                resp_lat   <= resp_val;
                inject_lat <= inject_err;
            end
        end
    end

    // Outputs are registered from the next state, so a/b/busy line up with the state they describe.
    always_comb begin
        state_n = state;
        dly_n   = dly_cnt;
        rep_n   = rep_cnt;
        cnt_n   = seq_cnt;
        a_n     = A_IDLE_V;
        b_n     = B_IDLE_V;
        done_n  = 1'b0;
        latch   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    rep_n   = (reps == 8'd0) ? 8'd1 : reps;
                    state_n = ST_TRIG;
                    a_n     = trig_val;
                end
            end
            ST_TRIG: begin
                dly_n = dly_lat - 4'd1;
                if (dly_lat == 4'd1) begin
                    state_n = ST_RESP;
                    b_n     = resp_eff;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dly_n = dly_cnt - 4'd1;
                if (dly_cnt == 4'd1) begin
                    state_n = ST_RESP;
                    b_n     = resp_eff;
                end
            end
            ST_RESP: begin
                cnt_n = seq_cnt + 8'd1;
                if (rep_cnt == 8'd1) begin
                    rep_n   = 8'd0;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    rep_n   = rep_cnt - 8'd1;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                state_n = ST_TRIG;
                a_n     = trig_lat;
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_seq_stim_gen.sv
// tb/tb_seq_stim_gen.sv - directed self-checking bench for seq_stim_gen
module tb_seq_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  delay_cfg = '0;
    logic [7:0]  reps = '0;
    logic        inject_err = 1'b0;
    logic [31:0] trig_val = '0;
    logic [31:0] resp_val = '0;
    logic [31:0] a, b;
    logic        busy, done;
    logic [7:0]  seq_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int err_pairs = 0;

    seq_stim_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .delay_cfg(delay_cfg),
        .reps(reps), .inject_err(inject_err), .trig_val(trig_val),
        .resp_val(resp_val), .a(a), .b(b), .busy(busy), .done(done),
        .seq_cnt(seq_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one start and checks every cycle until the done cycle; poke pulses start with
    // scrambled config during the first WAIT cycle to prove busy-time starts are ignored.
    task automatic run_seq(input int dcfg, input int rcfg, input bit inj,
                           input logic [31:0] tv, input logic [31:0] rv, input bit poke);
        int d, n, total, j, pair;
        d = (dcfg == 0) ? 1 : dcfg;
        n = (rcfg == 0) ? 1 : rcfg;
        total = n * (d + 2);
        @(negedge clk);
        delay_cfg = 4'(dcfg); reps = 8'(rcfg); inject_err = inj;
        trig_val = tv; resp_val = rv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk);
            j = (i - 1) % (d + 2);
            pair = (i - 1) / (d + 2);
            check($sformatf("a[c%0d]", i), a, (j == 0 && pair < n) ? tv : 32'd1);
            check($sformatf("b[c%0d]", i), b, (j == d && pair < n) ? rv + 32'(inj) : 32'd4);
            check($sformatf("busy[c%0d]", i), 32'(busy), 32'(i < total));
            check($sformatf("done[c%0d]", i), 32'(done), 32'(i == total));
            if (j == d && pair < n && b != rv) err_pairs++;
            if (poke && i == 2) begin
                start = 1'b1; delay_cfg = 4'd1; reps = 8'd9;
                trig_val = 32'hdead; resp_val = 32'hbeef; inject_err = ~inj;
            end
            if (poke && i == 3) start = 1'b0;
        end
        exp_cnt = (exp_cnt + n) % 256;
        check("seq_cnt_end", 32'(seq_cnt), 32'(exp_cnt));
    endtask

    initial begin
        // reset and idle hold
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_a", a, 32'd1);
            check("idle_b", b, 32'd4);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_cnt", 32'(seq_cnt), 32'd0);
        end

        // basic pair, repeat with inject, clamping, back-to-back
        run_seq(5, 1, 1'b0, 32'd0, 32'd2, 1'b0);
        check("basic_cnt", 32'(seq_cnt), 32'd1);
        err_pairs = 0;
        run_seq(3, 3, 1'b1, 32'd0, 32'd2, 1'b0);
        check("inject_errs", 32'(err_pairs), 32'd3);
        check("inject_cnt", 32'(seq_cnt), 32'd4);
        run_seq(0, 0, 1'b0, 32'h11, 32'h22, 1'b0);
        check("clamp_cnt", 32'(seq_cnt), 32'd5);
        run_seq(1, 2, 1'b1, 32'h5, 32'hffffffff, 1'b0);
        run_seq(15, 1, 1'b0, 32'h7, 32'h8, 1'b0);

        // start during WAIT ignored, latched config intact
        run_seq(5, 2, 1'b0, 32'h77, 32'h99, 1'b1);
        @(negedge clk);
        check("poke_idle_busy", 32'(busy), 32'd0);

        // wrap: 256 single-pair runs from reset
        rst_n = 1'b0;
        #1 check("wrap_rst_cnt", 32'(seq_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 256; r++) run_seq(1, 1, 1'b0, 32'h3, 32'h6, 1'b0);
        check("wrap_cnt", 32'(seq_cnt), 32'd0);

        // reset during WAIT of pair 2 of 4 (delay 4: pair period 6, pair 2 WAIT at c8..c10)
        @(negedge clk);
        delay_cfg = 4'd4; reps = 8'd4; inject_err = 1'b0;
        trig_val = 32'h10; resp_val = 32'h20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'd1);
        check("mid_cnt_pre", 32'(seq_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", a, 32'd1);
        check("mid_rst_b", b, 32'd4);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(seq_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_b", b, 32'd4);
            check("post_rst_cnt", 32'(seq_cnt), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
